// File: rtl/seq_checker.sv
// Receive-side checker for the 4-bit ramp patterns of the sequence generator.
// Hunts for a frame start, tracks the expected value, reports lock, errors and completed periods.
module seq_checker #(
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8,
  parameter int FRM_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             seq_valid,
  input  logic [3:0]       seq_in,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             frame_done,
  output logic [FRM_W-1:0] frame_cnt,
  output logic [3:0]       exp_out
);

  localparam logic [0:0] ST_HUNT  = 1'b0;
  localparam logic [0:0] ST_CHECK = 1'b1;

  localparam logic [1:0] MODE_SEQ  = 2'd0;
  localparam logic [1:0] MODE_EVN  = 2'd1;
  localparam logic [1:0] MODE_ODD  = 2'd2;
  localparam logic [1:0] MODE_ODD4 = 2'd3;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

  // In-ramp successor of v for pattern m.
  function automatic logic [3:0] f_step(input logic [1:0] m, input logic [3:0] v);
    logic [3:0] inc;
    if (m == MODE_ODD4) begin
      if (v == 4'd0 || v == 4'd7) begin
        inc = 4'd1;
      end else if (v == 4'd8) begin
        inc = 4'd3;
      end else begin
        inc = 4'd2;
      end
    end else begin
      inc = 4'd1;
    end
    return v + inc;
  endfunction

  function automatic logic [3:0] f_next_base(input logic [1:0] m, input logic [3:0] b);
    logic [3:0] nb;
    case (m)
      MODE_SEQ: nb = (b == 4'd14) ? 4'd0 : b + 4'd1;
      MODE_EVN: nb = (b == 4'd14) ? 4'd0 : b + 4'd2;
      MODE_ODD: nb = (b == 4'd0) ? 4'd1 : ((b == 4'd13) ? 4'd0 : b + 4'd2);
      default:  nb = 4'd0;
    endcase
    return nb;
  endfunction

  // True when the ramp starting at b is the last one of the period.
  function automatic logic f_last_base(input logic [1:0] m, input logic [3:0] b);
    logic last;
    case (m)
      MODE_SEQ: last = (b == 4'd14);
      MODE_EVN: last = (b == 4'd14);
      MODE_ODD: last = (b == 4'd13);
      default:  last = 1'b1;
    endcase
    return last;
  endfunction

  logic [0:0]       r_state;
  logic [1:0]       r_mode;
  logic [3:0]       r_exp;
  logic [3:0]       r_base;
  logic [3:0]       r_match_cnt;
  logic             r_locked;
  logic             r_err;
  logic             r_frame_done;
  logic [ERR_W-1:0] r_err_cnt;
  logic [FRM_W-1:0] r_frame_cnt;

  logic [0:0]       w_state_nxt;
  logic [1:0]       w_mode_nxt;
  logic [3:0]       w_exp_nxt;
  logic [3:0]       w_base_nxt;
  logic [3:0]       w_match_nxt;
  logic             w_locked_nxt;
  logic             w_err_nxt;
  logic             w_frame_nxt;
  logic [ERR_W-1:0] w_err_cnt_nxt;
  logic [FRM_W-1:0] w_frame_cnt_nxt;
  logic [3:0]       w_match_inc;
  logic             w_hit;

  assign w_match_inc = (r_match_cnt >= LOCK_TGT) ? LOCK_TGT : r_match_cnt + 4'd1;
  assign w_hit       = (r_state == ST_CHECK) && (seq_in == r_exp);

  // Next-state evaluation: mode change first, then the valid-sample compare, then counter clear.
  always_comb begin
    w_state_nxt     = r_state;
    w_mode_nxt      = r_mode;
    w_exp_nxt       = r_exp;
    w_base_nxt      = r_base;
    w_match_nxt     = r_match_cnt;
    w_locked_nxt    = r_locked;
    w_err_nxt       = 1'b0;
    w_frame_nxt     = 1'b0;
    w_err_cnt_nxt   = r_err_cnt;
    w_frame_cnt_nxt = r_frame_cnt;

    if (mode != r_mode) begin
      // The sample coinciding with a mode change is discarded.
      w_mode_nxt   = mode;
      w_state_nxt  = ST_HUNT;
      w_exp_nxt    = 4'd0;
      w_base_nxt   = 4'd0;
      w_match_nxt  = 4'd0;
      w_locked_nxt = 1'b0;
    end else if (seq_valid) begin
      if (w_hit) begin
        w_match_nxt  = w_match_inc;
        w_locked_nxt = r_locked | (w_match_inc >= LOCK_TGT);
        if (seq_in == 4'd15) begin
          w_base_nxt = f_next_base(r_mode, r_base);
          w_exp_nxt  = f_next_base(r_mode, r_base);
          if (f_last_base(r_mode, r_base) && (r_locked || (w_match_inc >= LOCK_TGT))) begin
            w_frame_nxt     = 1'b1;
            w_frame_cnt_nxt = r_frame_cnt + FRM_W'(1);
          end else begin
            w_frame_nxt = 1'b0;
          end
        end else begin
          w_exp_nxt = f_step(r_mode, seq_in);
        end
      end else begin
        if ((r_state == ST_CHECK) && r_locked) begin
          w_err_nxt     = 1'b1;
          w_err_cnt_nxt = (r_err_cnt == {ERR_W{1'b1}}) ? r_err_cnt : r_err_cnt + ERR_W'(1);
        end else begin
          w_err_nxt = 1'b0;
        end
        // A 0 restarts tracking immediately, exactly as a fresh frame start from HUNT.
        if (seq_in == 4'd0) begin
          w_state_nxt  = ST_CHECK;
          w_base_nxt   = 4'd0;
          w_exp_nxt    = f_step(r_mode, 4'd0);
          w_match_nxt  = 4'd1;
          w_locked_nxt = (4'd1 >= LOCK_TGT);
        end else begin
          w_state_nxt  = ST_HUNT;
          w_base_nxt   = 4'd0;
          w_exp_nxt    = 4'd0;
          w_match_nxt  = 4'd0;
          w_locked_nxt = 1'b0;
        end
      end
    end else begin
      w_state_nxt = r_state;
    end

    if (clr_cnt) begin
      w_err_cnt_nxt   = {ERR_W{1'b0}};
      w_frame_cnt_nxt = {FRM_W{1'b0}};
    end else begin
      w_err_cnt_nxt   = w_err_cnt_nxt;
    end
  end

  // State and output registers; reset captures the current mode so a static mode is not seen as a change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_HUNT;
      r_mode       <= mode;
      r_exp        <= 4'd0;
      r_base       <= 4'd0;
      r_match_cnt  <= 4'd0;
      r_locked     <= 1'b0;
      r_err        <= 1'b0;
      r_frame_done <= 1'b0;
      r_err_cnt    <= {ERR_W{1'b0}};
      r_frame_cnt  <= {FRM_W{1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_mode       <= w_mode_nxt;
      r_exp        <= w_exp_nxt;
      r_base       <= w_base_nxt;
      r_match_cnt  <= w_match_nxt;
      r_locked     <= w_locked_nxt;
      r_err        <= w_err_nxt;
      r_frame_done <= w_frame_nxt;
      r_err_cnt    <= w_err_cnt_nxt;
      r_frame_cnt  <= w_frame_cnt_nxt;
    end
  end

  assign locked     = r_locked;
  assign err        = r_err;
  assign err_cnt    = r_err_cnt;
  assign frame_done = r_frame_done;
  assign frame_cnt  = r_frame_cnt;
  assign exp_out    = r_exp;

endmodule

// File: tb/tb_seq_checker.sv
// Self-checking bench for seq_checker: hand vector table, directed corner sequences,
// and randomized streams checked against a period-list reference model.
module tb_seq_checker;

  localparam int LOCK = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic       seq_valid = 1'b0;
  logic [3:0] seq_in = 4'd0;
  logic       clr_cnt = 1'b0;
  logic       locked, err, frame_done;
  logic [7:0] err_cnt, frame_cnt;
  logic [3:0] exp_out;

  int checks = 0;
  int errors = 0;

  seq_checker #(.LOCK_CNT(LOCK), .ERR_W(8), .FRM_W(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .seq_valid(seq_valid), .seq_in(seq_in),
    .clr_cnt(clr_cnt), .locked(locked), .err(err), .err_cnt(err_cnt),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .exp_out(exp_out)
  );

  always #5 clk = ~clk;

  // Full period of each mode as a flat list of sample values.
  logic [3:0] per [4][135];
  int         plen [4];

  // Reference model state.
  logic [1:0] m_mode;
  bit         m_hunt;
  int         m_pos, m_match, m_ecnt, m_fcnt;
  bit         m_locked, m_err, m_frame;

  typedef struct {
    logic       rst;
    logic [1:0] mode;
    logic       valid;
    logic [3:0] seq;
    logic       clr;
    logic       locked;
    logic       err;
    logic       frame;
    logic [3:0] expv;
  } vec_t;
  vec_t tbl [14];

  task automatic build_periods();
    int n;
    int b3 [9] = '{0, 1, 3, 5, 7, 8, 11, 13, 15};
    n = 0;
    for (int b = 0; b <= 14; b++) for (int v = b; v <= 15; v++) begin per[0][n] = 4'(v); n++; end
    plen[0] = n;
    n = 0;
    for (int b = 0; b <= 14; b += 2) for (int v = b; v <= 15; v++) begin per[1][n] = 4'(v); n++; end
    plen[1] = n;
    n = 0;
    for (int v = 0; v <= 15; v++) begin per[2][n] = 4'(v); n++; end
    for (int b = 1; b <= 13; b += 2) for (int v = b; v <= 15; v++) begin per[2][n] = 4'(v); n++; end
    plen[2] = n;
    for (int i = 0; i < 9; i++) per[3][i] = 4'(b3[i]);
    plen[3] = 9;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_update();
    m_err = 1'b0;
    m_frame = 1'b0;
    if (rst) begin
      m_mode = mode; m_hunt = 1'b1; m_pos = 0; m_match = 0; m_locked = 1'b0;
      m_ecnt = 0; m_fcnt = 0;
      return;
    end
    if (mode != m_mode) begin
      m_mode = mode; m_hunt = 1'b1; m_match = 0; m_locked = 1'b0;
    end else if (seq_valid) begin
      if (!m_hunt && seq_in == per[m_mode][m_pos]) begin
        bit last;
        last = (m_pos == plen[m_mode] - 1);
        m_pos = (m_pos + 1) % plen[m_mode];
        m_match = (m_match + 1 > LOCK) ? LOCK : m_match + 1;
        if (m_match >= LOCK) m_locked = 1'b1;
        if (last && m_locked) begin m_frame = 1'b1; m_fcnt = (m_fcnt + 1) % 256; end
      end else begin
        if (!m_hunt && m_locked) begin m_err = 1'b1; if (m_ecnt < 255) m_ecnt++; end
        m_locked = 1'b0; m_match = 0;
        if (seq_in == 4'd0) begin
          m_hunt = 1'b0; m_pos = 1; m_match = 1; m_locked = (LOCK <= 1);
        end else begin
          m_hunt = 1'b1;
        end
      end
    end
    if (clr_cnt) begin m_ecnt = 0; m_fcnt = 0; end
  endtask

  // One clock: apply inputs, advance model at the edge, compare all outputs just after it.
  task automatic drive(input logic r, input logic [1:0] md, input logic v,
                       input logic [3:0] s, input logic c);
    rst = r; mode = md; seq_valid = v; seq_in = s; clr_cnt = c;
    @(posedge clk);
    model_update();
    #1;
    chk("locked", locked, m_locked);
    chk("err", err, m_err);
    chk("frame_done", frame_done, m_frame);
    chk("err_cnt", err_cnt, m_ecnt);
    chk("frame_cnt", frame_cnt, m_fcnt);
    chk("exp_out", exp_out, m_hunt ? 0 : per[m_mode][m_pos]);
  endtask

  task automatic play(input logic [1:0] md, input int from, input int to);
    for (int i = from; i <= to; i++) drive(1'b0, md, 1'b1, per[md][i % plen[md]], 1'b0);
  endtask

  initial begin
    int fcount, prev_ecnt, gpos, r;
    logic [1:0] gmode;
    logic [3:0] s;
    logic v, c, rr;

    build_periods();

    // Mode 3 lock, one frame, an error and a gap; expectations worked out by hand.
    tbl[0]  = '{1'b1, 2'd3, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[1]  = '{1'b0, 2'd3, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
    tbl[2]  = '{1'b0, 2'd3, 1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 4'd3};
    tbl[3]  = '{1'b0, 2'd3, 1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 1'b0, 4'd5};
    tbl[4]  = '{1'b0, 2'd3, 1'b1, 4'd5,  1'b0, 1'b1, 1'b0, 1'b0, 4'd7};
    tbl[5]  = '{1'b0, 2'd3, 1'b1, 4'd7,  1'b0, 1'b1, 1'b0, 1'b0, 4'd8};
    tbl[6]  = '{1'b0, 2'd3, 1'b1, 4'd8,  1'b0, 1'b1, 1'b0, 1'b0, 4'd11};
    tbl[7]  = '{1'b0, 2'd3, 1'b1, 4'd11, 1'b0, 1'b1, 1'b0, 1'b0, 4'd13};
    tbl[8]  = '{1'b0, 2'd3, 1'b1, 4'd13, 1'b0, 1'b1, 1'b0, 1'b0, 4'd15};
    tbl[9]  = '{1'b0, 2'd3, 1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0};
    tbl[10] = '{1'b0, 2'd3, 1'b1, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[11] = '{1'b0, 2'd3, 1'b1, 4'd2,  1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
    tbl[12] = '{1'b0, 2'd3, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
    tbl[13] = '{1'b0, 2'd3, 1'b0, 4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 4'd1};

    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].mode, tbl[i].valid, tbl[i].seq, tbl[i].clr);
      chk("tbl_locked", locked, tbl[i].locked);
      chk("tbl_err", err, tbl[i].err);
      chk("tbl_frame", frame_done, tbl[i].frame);
      chk("tbl_exp", exp_out, tbl[i].expv);
    end

    // Mode 3, two clean periods.
    drive(1'b1, 2'd3, 1'b0, 4'd0, 1'b0);
    play(2'd3, 0, 17);
    chk("m3_frame_cnt", frame_cnt, 2);
    chk("m3_err_cnt", err_cnt, 0);

    // Mode 0: corrupt the second value of the base-3 ramp.
    drive(1'b1, 2'd0, 1'b0, 4'd0, 1'b0);
    play(2'd0, 0, 45);
    drive(1'b0, 2'd0, 1'b1, 4'd9, 1'b0);
    chk("m0_err", err, 1);
    chk("m0_err_cnt", err_cnt, 1);
    chk("m0_unlock", locked, 0);
    chk("m0_hunt_exp", exp_out, 0);
    play(2'd0, 0, 2);
    chk("m0_not_yet", locked, 0);
    play(2'd0, 3, 3);
    chk("m0_relock", locked, 1);

    // Mode 1 with a gap after every valid sample.
    drive(1'b1, 2'd1, 1'b0, 4'd0, 1'b0);
    fcount = 0;
    for (int i = 0; i < 144; i++) begin
      drive(1'b0, 2'd1, 1'b1, per[1][i % 72], 1'b0);
      if (frame_done) fcount++;
      drive(1'b0, 2'd1, 1'b0, 4'($urandom_range(0, 15)), 1'b0);
      if (frame_done) fcount++;
      chk("gap_exp", exp_out, per[1][(i + 1) % 72]);
    end
    chk("m1_frames", fcount, 2);
    chk("m1_frame_cnt", frame_cnt, 2);

    // Mode 2 locked, then switch to mode 0 mid-ramp.
    drive(1'b1, 2'd2, 1'b0, 4'd0, 1'b0);
    play(2'd2, 0, 19);
    prev_ecnt = 0;
    drive(1'b0, 2'd0, 1'b1, 4'd4, 1'b0);
    chk("sw_locked", locked, 0);
    chk("sw_err", err, 0);
    chk("sw_err_cnt", err_cnt, prev_ecnt);
    drive(1'b0, 2'd0, 1'b1, 4'd5, 1'b0);
    play(2'd0, 0, 3);
    chk("sw_relock", locked, 1);

    // Error counter saturation, then clear coinciding with an error.
    drive(1'b1, 2'd0, 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 256; k++) begin
      play(2'd0, 0, 3);
      drive(1'b0, 2'd0, 1'b1, 4'd5, 1'b0);
    end
    chk("sat_err", err, 1);
    chk("sat_err_cnt", err_cnt, 255);
    play(2'd0, 0, 3);
    drive(1'b0, 2'd0, 1'b1, 4'd5, 1'b1);
    chk("clr_err", err, 1);
    chk("clr_err_cnt", err_cnt, 0);

    // Reset while locked, then resume on a non-zero value.
    play(2'd0, 0, 10);
    drive(1'b1, 2'd0, 1'b1, 4'd11, 1'b0);
    chk("rst_locked", locked, 0);
    chk("rst_exp", exp_out, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    play(2'd0, 12, 14);
    chk("rst_hunt", locked, 0);
    chk("rst_hunt_exp", exp_out, 0);
    play(2'd0, 0, 3);
    chk("rst_relock", locked, 1);

    // Frame counter wrap: 257 mode-3 periods.
    drive(1'b1, 2'd3, 1'b0, 4'd0, 1'b0);
    play(2'd3, 0, 257 * 9 - 1);
    chk("wrap_frame_cnt", frame_cnt, 1);

    // Randomized mostly-clean streams with errors, gaps, clears, mode changes and resets.
    gmode = 2'd0;
    gpos = 0;
    drive(1'b1, gmode, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      rr = (r >= 5 && r < 7);
      c = (r >= 7 && r < 12);
      if (r < 5) begin gmode = 2'($urandom_range(0, 3)); gpos = 0; end
      v = ($urandom_range(0, 3) != 0);
      s = per[gmode][gpos];
      if ($urandom_range(0, 99) < 3) s = 4'($urandom_range(0, 15));
      if (v) gpos = (gpos + 1) % plen[gmode];
      drive(rr, gmode, v, s, c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
